// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sysbus_pkg
// Brief    : Shared sysbus arbiter FSM state encoding and tag-bit constants.
// Revision : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_ACKREQ    = 3'd1;
    localparam logic [2:0] c_ST_WRCOLLECT = 3'd2;
    localparam logic [2:0] c_ST_WRADDR    = 3'd3;
    localparam logic [2:0] c_ST_WRDATA    = 3'd4;
    localparam logic [2:0] c_ST_RDADDR    = 3'd5;
    localparam logic [2:0] c_ST_RDRECV    = 3'd6;
    localparam logic [2:0] c_ST_RDRESP    = 3'd7;

    // Value of the tag MSB that marks a write burst.
    localparam logic c_SYSBUS_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sysbus_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant
// Brief    : Combinational round-robin picker, searching from one past 'last'.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant
    import sysbus_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] grant_idx
);

    localparam int c_IW = $clog2(NCH);

    int              cand;
    logic [c_IW-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant     = '0;
        grant_idx = last;
        cand      = 0;
        idx       = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = (int'(last) + i) % NCH;
            idx  = c_IW'(cand);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_arbiter
// Brief    : Arbitrates NCH burst clients onto one sysbus memory port.
// Revision : 1.0 - initial release
// ============================================================================
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int NCH            = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic [NCH-1:0]                           reqcyc,
    output logic [NCH-1:0]                           reqack,
    input  logic [NCH-1:0][BUS_DATA_WIDTH-1:0]       req,
    input  logic [NCH-1:0][BUS_TAG_WIDTH-1:0]        reqtag,

    output logic [NCH-1:0]                           respcyc,
    input  logic [NCH-1:0]                           respack,
    output logic [NCH-1:0][BUS_DATA_WIDTH-1:0]       resp,
    output logic [NCH-1:0][BUS_TAG_WIDTH-1:0]        resptag,

    output logic                                     bus_reqcyc,
    input  logic                                     bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]                bus_req,
    output logic [BUS_TAG_WIDTH-1:0]                 bus_reqtag,
    input  logic                                     bus_respcyc,
    output logic                                     bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]                bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]                 bus_resptag,

    output logic [$clog2(NCH)-1:0]                   grant_id
);

    localparam int              c_IW        = $clog2(NCH);
    localparam int              c_BW        = $clog2(BEATS);
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(BEATS - 1);
    localparam logic [c_IW-1:0] c_LAST_CH   = c_IW'(NCH - 1);

    state_t                                 state_q, state_d;
    logic [c_BW-1:0]                        beat_q, beat_d;
    logic [c_IW-1:0]                        grant_q, grant_d;
    logic [BUS_DATA_WIDTH-1:0]              addr_q, addr_d;
    logic [BUS_TAG_WIDTH-1:0]               tag_q, tag_d;
    logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   buf_q, buf_d;

    logic [NCH-1:0]                         w_rr_oh;
    logic [c_IW-1:0]                        w_rr_idx;
    logic                                   w_unused_resptag;

    // Responses are matched by burst order, so the returned tag carries no information here.
    assign w_unused_resptag = ^bus_resptag;

    rr_grant #(
        .NCH       (NCH)
    ) u_rr_grant (
        .req       (reqcyc),
        .last      (grant_q),
        .grant     (w_rr_oh),
        .grant_idx (w_rr_idx)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        buf_d       = buf_q;

        reqack      = '0;
        respcyc     = '0;
        resp        = '0;
        resptag     = '0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        grant_id    = grant_q;

        // Every handshake is suppressed while reset is asserted, whatever the old state was.
        if (!reset) begin
            case (state_q)
                c_ST_IDLE: begin
                    if (|w_rr_oh) begin
                        grant_d = w_rr_idx;
                        addr_d  = req[w_rr_idx];
                        tag_d   = reqtag[w_rr_idx];
                        state_d = c_ST_ACKREQ;
                    end
                end

                c_ST_ACKREQ: begin
                    reqack[grant_q] = 1'b1;
                    beat_d          = '0;
                    state_d         = (tag_q[BUS_TAG_WIDTH-1] == c_SYSBUS_WRITE)
                                    ? c_ST_WRCOLLECT : c_ST_RDADDR;
                end

                c_ST_WRCOLLECT: begin
                    if (reqcyc[grant_q]) begin
                        reqack[grant_q] = 1'b1;
                        buf_d[beat_q]   = req[grant_q];
                        beat_d          = beat_q + 1'b1;
                        if (beat_q == c_LAST_BEAT) begin
                            state_d = c_ST_WRADDR;
                        end
                    end
                end

                c_ST_WRADDR: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = addr_q;
                    bus_reqtag = tag_q;
                    if (bus_reqack) begin
                        beat_d  = '0;
                        state_d = c_ST_WRDATA;
                    end
                end

                c_ST_WRDATA: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = buf_q[beat_q];
                    bus_reqtag = tag_q;
                    if (bus_reqack) begin
                        beat_d = beat_q + 1'b1;
                        if (beat_q == c_LAST_BEAT) begin
                            state_d = c_ST_IDLE;
                        end
                    end
                end

                c_ST_RDADDR: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = addr_q;
                    bus_reqtag = tag_q;
                    if (bus_reqack) begin
                        beat_d  = '0;
                        state_d = c_ST_RDRECV;
                    end
                end

                c_ST_RDRECV: begin
                    if (bus_respcyc) begin
                        bus_respack   = 1'b1;
                        buf_d[beat_q] = bus_resp;
                        beat_d        = beat_q + 1'b1;
                        if (beat_q == c_LAST_BEAT) begin
                            state_d = c_ST_RDRESP;
                        end
                    end
                end

                c_ST_RDRESP: begin
                    respcyc[grant_q] = 1'b1;
                    resp[grant_q]    = buf_q[beat_q];
                    resptag[grant_q] = tag_q;
                    if (respack[grant_q]) begin
                        beat_d = beat_q + 1'b1;
                        if (beat_q == c_LAST_BEAT) begin
                            state_d = c_ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            beat_q  <= '0;
            grant_q <= c_LAST_CH;
            addr_q  <= '0;
            tag_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            buf_q   <= buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysbus_arbiter
// Brief    : Directed self-checking bench for sysbus_arbiter (2x8 and 4x4 builds).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sysbus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Default build: NCH=2, BEATS=8
    logic [1:0]         a_reqcyc, a_reqack, a_respcyc, a_respack;
    logic [1:0][DW-1:0] a_req, a_resp;
    logic [1:0][TW-1:0] a_reqtag, a_resptag;
    logic               a_bus_reqcyc, a_bus_reqack, a_bus_respcyc, a_bus_respack;
    logic [DW-1:0]      a_bus_req, a_bus_resp;
    logic [TW-1:0]      a_bus_reqtag, a_bus_resptag;
    logic [0:0]         a_grant_id;

    // Wide build: NCH=4, BEATS=4
    logic [3:0]         b_reqcyc, b_reqack, b_respcyc, b_respack;
    logic [3:0][DW-1:0] b_req, b_resp;
    logic [3:0][TW-1:0] b_reqtag, b_resptag;
    logic               b_bus_reqcyc, b_bus_reqack, b_bus_respcyc, b_bus_respack;
    logic [DW-1:0]      b_bus_req, b_bus_resp;
    logic [TW-1:0]      b_bus_reqtag, b_bus_resptag;
    logic [1:0]         b_grant_id;

    sysbus_arbiter dut_a (
        .clk(clk), .reset(reset),
        .reqcyc(a_reqcyc), .reqack(a_reqack), .req(a_req), .reqtag(a_reqtag),
        .respcyc(a_respcyc), .respack(a_respack), .resp(a_resp), .resptag(a_resptag),
        .bus_reqcyc(a_bus_reqcyc), .bus_reqack(a_bus_reqack), .bus_req(a_bus_req),
        .bus_reqtag(a_bus_reqtag), .bus_respcyc(a_bus_respcyc), .bus_respack(a_bus_respack),
        .bus_resp(a_bus_resp), .bus_resptag(a_bus_resptag), .grant_id(a_grant_id)
    );

    sysbus_arbiter #(.NCH(4), .BEATS(4)) dut_b (
        .clk(clk), .reset(reset),
        .reqcyc(b_reqcyc), .reqack(b_reqack), .req(b_req), .reqtag(b_reqtag),
        .respcyc(b_respcyc), .respack(b_respack), .resp(b_resp), .resptag(b_resptag),
        .bus_reqcyc(b_bus_reqcyc), .bus_reqack(b_bus_reqack), .bus_req(b_bus_req),
        .bus_reqtag(b_bus_reqtag), .bus_respcyc(b_bus_respcyc), .bus_respack(b_bus_respack),
        .bus_resp(b_bus_resp), .bus_resptag(b_bus_resptag), .grant_id(b_grant_id)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_ack_a(output int ch);
        ch = -1;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (a_reqack != 2'b00) begin
                ch = a_reqack[1] ? 1 : 0;
                return;
            end
            step();
        end
        check_eq("a_reqack_timeout", 64'(a_reqack), 64'h1);
    endtask

    task automatic wait_ack_b(output int ch);
        ch = -1;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (b_reqack != 4'b0000) begin
                for (int i = 3; i >= 0; i--) begin
                    if (b_reqack[2'(i)]) ch = i;
                end
                return;
            end
            step();
        end
        check_eq("b_reqack_timeout", 64'(b_reqack), 64'h1);
    endtask

    task automatic rd_a(input int exp_ch, input logic [63:0] addr, input logic [TW-1:0] tag,
                        input logic [63:0] base, input int dly, input bit tgl, input bit drop);
        int         ch;
        int         k;
        int         cyc;
        logic       ack;
        logic [0:0] ci;
        ci = 1'(exp_ch);
        wait_ack_a(ch);
        check_eq("rd_grant", 64'(ch), 64'(exp_ch));
        check_eq("rd_grant_id", 64'(a_grant_id), 64'(exp_ch));
        check_eq("rd_ack_onehot", 64'(a_reqack), 64'(1) << exp_ch);
        if (drop) a_reqcyc = 2'b00;
        step();
        for (int d = 0; d < dly; d++) begin
            settle();
            check_eq("rd_addr_hold", 64'(a_bus_reqcyc), 64'h1);
            step();
        end
        a_bus_reqack = 1'b1;
        settle();
        check_eq("rd_bus_reqcyc", 64'(a_bus_reqcyc), 64'h1);
        check_eq("rd_addr", a_bus_req, addr);
        check_eq("rd_addr_tag", 64'(a_bus_reqtag), 64'(tag));
        step();
        a_bus_reqack = 1'b0;
        for (k = 0; k < 8; k++) begin
            if (tgl && (k % 2 == 1)) begin
                a_bus_respcyc = 1'b0;
                settle();
                check_eq("rd_respack_idle", 64'(a_bus_respack), 64'h0);
                step();
            end
            a_bus_respcyc = 1'b1;
            a_bus_resp    = base + 64'(k);
            settle();
            check_eq("rd_bus_respack", 64'(a_bus_respack), 64'h1);
            step();
        end
        a_bus_respcyc = 1'b0;
        a_bus_resp    = '0;
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            ack           = tgl ? (cyc % 2 == 1) : 1'b1;
            a_respack[ci] = ack;
            settle();
            check_eq("rd_respcyc", 64'(a_respcyc), 64'(1) << exp_ch);
            check_eq("rd_data", a_resp[ci], base + 64'(k));
            check_eq("rd_resptag", 64'(a_resptag[ci]), 64'(tag));
            check_eq("rd_other_resp", a_resp[~ci], 64'h0);
            check_eq("rd_holdoff", 64'(a_reqack), 64'h0);
            step();
            if (ack) k++;
            cyc++;
        end
        a_respack = 2'b00;
        check_eq("rd_beats", 64'(k), 64'd8);
        settle();
        check_eq("rd_done", 64'(a_respcyc), 64'h0);
    endtask

    task automatic wr_a(input int exp_ch, input logic [63:0] addr, input logic [TW-1:0] tag,
                        input logic [63:0] base, input int dly, input int rst_beat);
        int         ch;
        int         k;
        int         cyc;
        int         acks;
        bit         stall;
        logic [0:0] ci;
        ci           = 1'(exp_ch);
        a_reqcyc[ci] = 1'b1;
        a_req[ci]    = addr;
        a_reqtag[ci] = tag;
        wait_ack_a(ch);
        check_eq("wr_grant", 64'(ch), 64'(exp_ch));
        acks = (ch == exp_ch) ? 1 : 0;
        step();
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            stall        = (cyc == 2 || cyc == 3);
            a_reqcyc[ci] = !stall;
            a_req[ci]    = base + 64'(k);
            settle();
            check_eq("wr_collect_ack", 64'(a_reqack), stall ? 64'h0 : (64'(1) << exp_ch));
            if (a_reqack[ci]) acks++;
            if (!stall) k++;
            step();
            cyc++;
        end
        a_reqcyc = 2'b00;
        check_eq("wr_ack_count", 64'(acks), 64'd9);
        for (int d = 0; d < dly; d++) begin
            settle();
            check_eq("wr_addr_hold", 64'(a_bus_reqcyc), 64'h1);
            step();
        end
        a_bus_reqack = 1'b1;
        settle();
        check_eq("wr_bus_reqcyc", 64'(a_bus_reqcyc), 64'h1);
        check_eq("wr_addr", a_bus_req, addr);
        check_eq("wr_addr_tag", 64'(a_bus_reqtag), 64'(tag));
        step();
        a_bus_reqack = 1'b0;
        for (k = 0; k < 8; k++) begin
            if (k == rst_beat) begin
                reset = 1'b1;
                settle();
                check_eq("rst_in_valids", 64'({a_reqack, a_respcyc, a_bus_reqcyc, a_bus_respack}), 64'h0);
                check_eq("rst_in_bus_req", a_bus_req, 64'h0);
                step();
                reset = 1'b0;
                settle();
                check_eq("rst_after_valids", 64'({a_reqack, a_respcyc, a_bus_reqcyc, a_bus_respack}), 64'h0);
                return;
            end
            for (int d = 0; d < dly; d++) begin
                settle();
                check_eq("wr_data_hold", a_bus_req, base + 64'(k));
                step();
            end
            a_bus_reqack = 1'b1;
            settle();
            check_eq("wr_data_cyc", 64'(a_bus_reqcyc), 64'h1);
            check_eq("wr_data", a_bus_req, base + 64'(k));
            step();
            a_bus_reqack = 1'b0;
        end
        settle();
        check_eq("wr_done", 64'(a_bus_reqcyc), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         ch;
        logic [1:0] bi;
        reset         = 1'b1;
        a_reqcyc      = '0; a_req  = '0; a_reqtag = '0; a_respack = '0;
        a_bus_reqack  = 1'b0; a_bus_respcyc = 1'b0; a_bus_resp = '0; a_bus_resptag = '0;
        b_reqcyc      = '0; b_req  = '0; b_reqtag = '0; b_respack = '0;
        b_bus_reqack  = 1'b0; b_bus_respcyc = 1'b0; b_bus_resp = '0; b_bus_resptag = '0;
        repeat (3) step();
        settle();
        check_eq("reset_a_valids", 64'({a_reqack, a_respcyc, a_bus_reqcyc, a_bus_respack}), 64'h0);
        check_eq("reset_a_bus_req", a_bus_req, 64'h0);
        check_eq("reset_b_valids", 64'({b_reqack, b_respcyc, b_bus_reqcyc, b_bus_respack}), 64'h0);
        reset = 1'b0;
        step();
        settle();
        check_eq("post_reset_a_valids", 64'({a_reqack, a_respcyc, a_bus_reqcyc, a_bus_respack}), 64'h0);

        // Single read on ch0; bus returns 1..8
        a_reqcyc[0] = 1'b1; a_req[0] = 64'h1000; a_reqtag[0] = 13'h0042;
        rd_a(0, 64'h1000, 13'h0042, 64'h1, 0, 1'b0, 1'b1);

        // Write burst on ch1, A0..A7
        wr_a(1, 64'h2000, 13'h1005, 64'hA0, 0, -1);

        // Both channels held: grants must alternate 0,1,0,1
        a_req[0] = 64'h3000; a_reqtag[0] = 13'h0010;
        a_req[1] = 64'h3100; a_reqtag[1] = 13'h0021;
        a_reqcyc = 2'b11;
        for (int n = 0; n < 4; n++) begin
            rd_a(n % 2, (n % 2 == 1) ? 64'h3100 : 64'h3000, (n % 2 == 1) ? 13'h0021 : 13'h0010,
                 64'(16 * (n + 1)), 0, 1'b0, n == 3);
        end

        // Slow bus and throttled client
        a_reqcyc[1] = 1'b1; a_req[1] = 64'h4000; a_reqtag[1] = 13'h0033;
        rd_a(1, 64'h4000, 13'h0033, 64'h50, 5, 1'b1, 1'b1);
        wr_a(0, 64'h5000, 13'h1077, 64'hC0, 5, -1);

        // Reset in the middle of the write data phase
        wr_a(0, 64'h6000, 13'h1011, 64'hE0, 0, 3);
        a_bus_reqack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("rst_no_bus", 64'({a_bus_reqcyc, a_reqack}), 64'h0);
        end
        a_req[0] = 64'h7000; a_reqtag[0] = 13'h0001;
        a_req[1] = 64'h7100; a_reqtag[1] = 13'h0002;
        a_reqcyc = 2'b11;
        rd_a(0, 64'h7000, 13'h0001, 64'h70, 0, 1'b0, 1'b0);
        rd_a(1, 64'h7100, 13'h0002, 64'h78, 0, 1'b0, 1'b1);

        // Four-channel build: all reading at once
        for (int c = 0; c < 4; c++) begin
            bi           = 2'(c);
            b_req[bi]    = 64'h8000 + 64'(c * 256);
            b_reqtag[bi] = 13'(c + 1);
        end
        b_reqcyc = 4'hF;
        for (int n = 0; n < 4; n++) begin
            bi = 2'(n);
            wait_ack_b(ch);
            check_eq("b_grant", 64'(ch), 64'(n));
            b_reqcyc[bi] = 1'b0;
            step();
            b_bus_reqack = 1'b1;
            settle();
            check_eq("b_addr", b_bus_req, 64'h8000 + 64'(n * 256));
            step();
            b_bus_reqack = 1'b0;
            for (int k = 0; k < 4; k++) begin
                b_bus_respcyc = 1'b1;
                b_bus_resp    = 64'h900 + 64'(n * 16 + k);
                step();
            end
            b_bus_respcyc = 1'b0;
            for (int k = 0; k < 4; k++) begin
                b_respack[bi] = 1'b1;
                settle();
                check_eq("b_respcyc", 64'(b_respcyc), 64'(1) << n);
                check_eq("b_data", b_resp[bi], 64'h900 + 64'(n * 16 + k));
                check_eq("b_resptag", 64'(b_resptag[bi]), 64'(n + 1));
                step();
            end
            b_respack = 4'h0;
            settle();
            check_eq("b_done", 64'(b_respcyc), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, number of client channels (2..8).
REQ-002 SHALL have parameter BUS_DATA_WIDTH, default 64, data/address beat width.
REQ-003 SHALL have parameter BUS_TAG_WIDTH, default 13, tag width; tag[BUS_TAG_WIDTH-1]==`SYSBUS_WRITE marks a write.
REQ-004 SHALL have parameter BEATS, default 8, beats per burst (power of two, 2..16).
REQ-005 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset: synchronous, active-high).
REQ-006 SHALL have ports reqcyc (in, NCH), reqack (out, NCH), req (in, NCH x BUS_DATA_WIDTH), reqtag (in, NCH x BUS_TAG_WIDTH): client request side, indexed by channel.
REQ-007 SHALL have ports respcyc (out, NCH), respack (in, NCH), resp (out, NCH x BUS_DATA_WIDTH), resptag (out, NCH x BUS_TAG_WIDTH): client response side.
REQ-008 SHALL have ports bus_reqcyc (out, 1), bus_reqack (in, 1), bus_req (out, BUS_DATA_WIDTH), bus_reqtag (out, BUS_TAG_WIDTH), bus_respcyc (in, 1), bus_respack (out, 1), bus_resp (in, BUS_DATA_WIDTH), bus_resptag (in, BUS_TAG_WIDTH): memory side.
REQ-009 SHALL have port grant_id (out, $clog2(NCH)), index of the channel currently owning the bus (debug).

Function
REQ-010 SHALL use one registered FSM: IDLE, ACKREQ, WRCOLLECT, WRADDR, WRDATA, RDADDR, RDRECV, RDRESP.
REQ-011 IDLE: SHALL grant round-robin among asserted reqcyc, starting one past the last granted channel; capture req as address and reqtag as tag; go ACKREQ.
REQ-012 ACKREQ: SHALL assert reqack[grant] for exactly one cycle; next WRCOLLECT if write tag, else RDADDR.
REQ-013 WRCOLLECT: each cycle reqcyc[grant]=1, SHALL store req[grant] into buffer[beat] and pulse reqack[grant] that same cycle; after beat BEATS-1, go WRADDR; reqcyc low SHALL stall without state change.
REQ-014 WRADDR: SHALL hold bus_reqcyc=1, bus_req=address, bus_reqtag=tag until bus_reqack=1, then go WRDATA with beat=0.
REQ-015 WRDATA: SHALL hold bus_reqcyc=1, bus_req=buffer[beat]; each bus_reqack advances beat; ack on beat BEATS-1 returns to IDLE.
REQ-016 RDADDR: as WRADDR; on bus_reqack go RDRECV.
REQ-017 RDRECV: each cycle bus_respcyc=1, SHALL assert bus_respack combinationally and store bus_resp into buffer[beat]; after beat BEATS-1 go RDRESP with beat=0.
REQ-018 RDRESP: SHALL hold respcyc[grant]=1, resp[grant]=buffer[beat], resptag[grant]=tag; each cycle respack[grant]=1 advances beat (one beat/cycle throughput); ack on beat BEATS-1 returns to IDLE.
REQ-019 All reqack/respcyc of non-granted channels SHALL be 0; all resp/resptag/bus_req/bus_reqtag SHALL be 0 when not driven.
REQ-020 Beat counter SHALL be $clog2(BEATS) bits and wrap to 0 at burst end; no partial bursts.
REQ-021 Requests arriving while not IDLE SHALL be held off (no reqack) and served in round-robin order later.
REQ-022 A write burst's data SHALL reach the bus in client order, unmodified.
REQ-023 Every output SHALL be driven in one always_comb with defaults first (no latches, no multiple drivers).

Reset
REQ-024 On reset: state=IDLE, beat=0, buffer/address/tag=0, last-grant pointer=NCH-1 (channel 0 wins first).
REQ-025 In reset and the cycle after: all output valids/acks (reqack, respcyc, bus_reqcyc, bus_respack) SHALL be 0.
REQ-026 Reset mid-burst SHALL abandon the burst with no further bus or client handshake.

Structure
REQ-027 State enum and SYSBUS tag-bit constant SHALL live in shared package sysbus_pkg.
REQ-028 Round-robin selection SHALL be sub-module rr_grant (NCH-wide request, last pointer -> one-hot grant + index, combinational).

Verification
REQ-029 Read ch0, addr 0x1000, bus returns 0x1..0x8 -> ch0 sees resp 0x1..0x8, resptag=reqtag, returns IDLE.
REQ-030 Write ch1 beats 0xA0..0xA7 -> bus sees addr then 0xA0..0xA7 with write tag; ch1 gets 9 reqack pulses.
REQ-031 reqcyc[0] and reqcyc[1] held together for 4 reads -> grants 0,1,0,1.
REQ-032 bus_reqack delayed 5 cycles per beat, respack toggling -> data intact, no beat lost or duplicated.
REQ-033 reset during WRDATA beat 3 -> next cycle all acks/valids 0, state IDLE, ch0 next granted.
REQ-034 NCH=4, BEATS=4 build: all 4 channels reading simultaneously -> served 0,1,2,3, 4 beats each.
